// File: rtl/ahb_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_slave_if
// AHB-side front end of the AHB-to-APB bridge. Qualifies AHB transfers,
// decodes the address into a one-hot peripheral select, keeps two-stage
// address / write-data / direction pipelines for the APB controller and
// returns read data and the transfer response to the AHB master.
//
// Optional feature macro: AHB_SLV_ERR_RESP_EN
//   defined   : illegal transfers get a two-cycle AHB ERROR response
//   undefined : illegal transfers are silently dropped (OKAY response)
//
// Ports
//   hclk, hreset      clock, synchronous active-high reset
//   hsel, hwrite,
//   hready_in, htrans,
//   hsize, haddr,
//   hwdata            AHB master side inputs
//   prdata            APB read data
//   hr_readyout       ready from the APB controller
//   valid             qualified legal transfer this cycle (combinational)
//   temp_sel          one-hot peripheral select (combinational)
//   haddr_1/2,
//   hwdata_1/2,
//   hwrite_reg/_1     pipeline stages 1 and 2
//   hrdata            AHB read data (passthrough of prdata)
//   hreadyout, hresp  AHB ready and response
// ---------------------------------------------------------------------------
module ahb_slave_if #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter logic [31:0] SLV_SIZE  = 32'h0400_0000
) (
   input  logic                hclk,
   input  logic                hreset,
   input  logic                hsel,
   input  logic                hwrite,
   input  logic                hready_in,
   input  logic [1:0]          htrans,
   input  logic [2:0]          hsize,
   input  logic [31:0]         haddr,
   input  logic [31:0]         hwdata,
   input  logic [31:0]         prdata,
   input  logic                hr_readyout,
   output logic                valid,
   output logic [2:0]          temp_sel,
   output logic [31:0]         haddr_1,
   output logic [31:0]         haddr_2,
   output logic [31:0]         hwdata_1,
   output logic [31:0]         hwdata_2,
   output logic                hwrite_reg,
   output logic                hwrite_reg_1,
   output logic [31:0]         hrdata,
   output logic                hreadyout,
   output logic [1:0]          hresp
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   // Region limits kept two bits wider so 3*SLV_SIZE cannot wrap.
   localparam logic [AW+1:0] LIM1 = {2'b00, SLV_SIZE};
   localparam logic [AW+1:0] LIM2 = LIM1 + LIM1;
   localparam logic [AW+1:0] LIM3 = LIM2 + LIM1;

   logic [AW-1:0] off;
   logic          mapped;
   logic          aligned;
   logic          legal;
   logic          act;

   assign act = hsel & hready_in & htrans[1];
   assign off = haddr - BASE_ADDR;

   // Address decode; addresses below BASE_ADDR wrap to a huge offset.
   always_comb begin
      temp_sel = 3'b000;
      mapped   = 1'b1;
      if ({2'b00, off} < LIM1)      temp_sel = 3'b001;
      else if ({2'b00, off} < LIM2) temp_sel = 3'b010;
      else if ({2'b00, off} < LIM3) temp_sel = 3'b100;
      else                          mapped   = 1'b0;
   end

   // Size / natural alignment check; sizes above a word are illegal.
   always_comb begin
      aligned = 1'b0;
      case (hsize)
         3'b000:  aligned = 1'b1;
         3'b001:  aligned = ~haddr[0];
         3'b010:  aligned = (haddr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   assign legal  = mapped & aligned;
   assign hrdata = prdata;

   // Address, data and direction pipelines; frozen while the bus stalls.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         haddr_1      <= '0;
         haddr_2      <= '0;
         hwdata_1     <= DW'(0);
         hwdata_2     <= DW'(0);
         hwrite_reg   <= 1'b0;
         hwrite_reg_1 <= 1'b0;
      end else if (hready_in) begin
         haddr_1      <= haddr;
         haddr_2      <= haddr_1;
         hwdata_1     <= hwdata;
         hwdata_2     <= hwdata_1;
         hwrite_reg   <= hwrite;
         hwrite_reg_1 <= hwrite_reg;
      end
   end

`ifdef AHB_SLV_ERR_RESP_EN
   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_ERR1 = 2'b01;
   localparam logic [1:0] ST_ERR2 = 2'b10;

   logic [1:0] state;
   logic [1:0] state_nxt;

   // Error response state register.
   always_ff @(posedge hclk) begin
      if (hreset) state <= ST_OK;
      else        state <= state_nxt;
   end

   // Two-cycle ERROR: first cycle stalls the master, second completes it.
   always_comb begin
      state_nxt = state;
      hreadyout = hr_readyout;
      hresp     = 2'b00;
      valid     = act & legal & ~hreset;
      case (state)
         ST_OK: begin
            if (act & ~legal) state_nxt = ST_ERR1;
         end
         ST_ERR1: begin
            hreadyout = 1'b0;
            hresp     = 2'b01;
            valid     = 1'b0;
            state_nxt = ST_ERR2;
         end
         ST_ERR2: begin
            hreadyout = 1'b1;
            hresp     = 2'b01;
            state_nxt = (act & ~legal) ? ST_ERR1 : ST_OK;
         end
         default: state_nxt = ST_OK;
      endcase
   end
`else
   // Illegal transfers are dropped with an OKAY response.
   always_comb begin
      hreadyout = hr_readyout;
      hresp     = 2'b00;
      valid     = act & legal & ~hreset;
   end
`endif

endmodule

// File: tb/tb_ahb_slave_if.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_if
// Directed self-checking bench for ahb_slave_if. Inputs change 1 time unit
// after the rising edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ahb_slave_if;

`ifdef AHB_SLV_ERR_RESP_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        hclk = 1'b0;
   logic        hreset;
   logic        hsel;
   logic        hwrite;
   logic        hready_in;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic [31:0] prdata;
   logic        hr_readyout;
   logic        valid;
   logic [2:0]  temp_sel;
   logic [31:0] haddr_1;
   logic [31:0] haddr_2;
   logic [31:0] hwdata_1;
   logic [31:0] hwdata_2;
   logic        hwrite_reg;
   logic        hwrite_reg_1;
   logic [31:0] hrdata;
   logic        hreadyout;
   logic [1:0]  hresp;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_err_resp;
   logic [31:0] exp_err_ready;
   logic [31:0] exp_err_valid;

   always #5 hclk = ~hclk;

   ahb_slave_if dut (
      .hclk         (hclk),
      .hreset       (hreset),
      .hsel         (hsel),
      .hwrite       (hwrite),
      .hready_in    (hready_in),
      .htrans       (htrans),
      .hsize        (hsize),
      .haddr        (haddr),
      .hwdata       (hwdata),
      .prdata       (prdata),
      .hr_readyout  (hr_readyout),
      .valid        (valid),
      .temp_sel     (temp_sel),
      .haddr_1      (haddr_1),
      .haddr_2      (haddr_2),
      .hwdata_1     (hwdata_1),
      .hwdata_2     (hwdata_2),
      .hwrite_reg   (hwrite_reg),
      .hwrite_reg_1 (hwrite_reg_1),
      .hrdata       (hrdata),
      .hreadyout    (hreadyout),
      .hresp        (hresp)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge hclk);
      #1;
   endtask

   task automatic smp();
      @(negedge hclk);
   endtask

   initial begin
      exp_err_resp  = ERR_EN ? 32'd1 : 32'd0;
      exp_err_ready = ERR_EN ? 32'd0 : 32'd1;
      exp_err_valid = ERR_EN ? 32'd0 : 32'd1;

      // Reset with a legal transfer presented: valid must stay low
      hreset = 1'b1; hsel = 1'b1; hready_in = 1'b1; htrans = 2'b10;
      hsize = 3'b010; haddr = 32'h8000_0010; hwdata = 32'h1234_5678;
      hwrite = 1'b1; prdata = 32'h0BAD_F00D; hr_readyout = 1'b0;
      nxt();
      smp();
      chk("rst_valid",      32'(valid), 32'd0);
      chk("rst_haddr_1",    haddr_1, 32'h0);
      chk("rst_haddr_2",    haddr_2, 32'h0);
      chk("rst_hwdata_1",   hwdata_1, 32'h0);
      chk("rst_hwdata_2",   hwdata_2, 32'h0);
      chk("rst_hwrite_reg", 32'(hwrite_reg), 32'd0);
      chk("rst_hwrite_r1",  32'(hwrite_reg_1), 32'd0);
      chk("rst_hresp",      32'(hresp), 32'd0);
      chk("rst_hreadyout",  32'(hreadyout), 32'd0);
      chk("rst_hrdata",     hrdata, 32'h0BAD_F00D);
      nxt();
      hreset = 1'b0; hr_readyout = 1'b1; hwrite = 1'b0; hwdata = 32'h0;

      // Decode, region 0
      smp();
      chk("dec0_sel",     32'(temp_sel), 32'd1);
      chk("dec0_valid",   32'(valid), 32'd1);
      chk("dec0_haddr_1", haddr_1, 32'h0);
      chk("dec0_ready",   32'(hreadyout), 32'd1);
      nxt();
      haddr = 32'h8400_0000;
      smp();
      chk("dec1_sel",     32'(temp_sel), 32'd2);
      chk("dec1_valid",   32'(valid), 32'd1);
      chk("dec1_haddr_1", haddr_1, 32'h8000_0010);
      nxt();
      haddr = 32'h8BFF_FFFC;
      smp();
      chk("dec2_sel",     32'(temp_sel), 32'd4);
      chk("dec2_valid",   32'(valid), 32'd1);
      chk("dec2_haddr_2", haddr_2, 32'h8000_0010);
      nxt();
      haddr = 32'h8C00_0000;
      smp();
      chk("unmap_sel",   32'(temp_sel), 32'd0);
      chk("unmap_valid", 32'(valid), 32'd0);
      chk("unmap_hresp", 32'(hresp), 32'd0);
      nxt();
      htrans = 2'b00; haddr = 32'h8000_0010;
      smp();
      chk("unmap_e1_hresp", 32'(hresp), exp_err_resp);
      chk("unmap_e1_ready", 32'(hreadyout), exp_err_ready);
      chk("unmap_e1_valid", 32'(valid), 32'd0);
      nxt();
      htrans = 2'b10;
      smp();
      chk("unmap_e2_hresp", 32'(hresp), exp_err_resp);
      chk("unmap_e2_ready", 32'(hreadyout), 32'd1);
      chk("unmap_e2_valid", 32'(valid), 32'd1);
      chk("unmap_e2_sel",   32'(temp_sel), 32'd1);
      nxt();
      hsize = 3'b001; haddr = 32'h8400_0002;
      smp();
      chk("half_valid", 32'(valid), 32'd1);
      chk("half_sel",   32'(temp_sel), 32'd2);
      chk("half_hresp", 32'(hresp), 32'd0);
      nxt();
      htrans = 2'b00; hsize = 3'b010; haddr = 32'h7FFF_FFFC;
      smp();
      chk("below_sel",   32'(temp_sel), 32'd0);
      chk("below_valid", 32'(valid), 32'd0);

      // Write pipeline
      nxt();
      htrans = 2'b10; haddr = 32'h8000_0004; hwrite = 1'b1; hwdata = 32'h0;
      smp();
      chk("wr_valid", 32'(valid), 32'd1);
      chk("wr_sel",   32'(temp_sel), 32'd1);
      nxt();
      htrans = 2'b00; haddr = 32'h8000_0100; hwrite = 1'b0; hwdata = 32'hDEAD_BEEF;
      smp();
      chk("wr_haddr_1",    haddr_1, 32'h8000_0004);
      chk("wr_hwrite_reg", 32'(hwrite_reg), 32'd1);
      chk("wr_hwdata_1a",  hwdata_1, 32'h0);
      nxt();
      haddr = 32'h8000_0200; hwdata = 32'h0;
      smp();
      chk("wr_haddr_2",    haddr_2, 32'h8000_0004);
      chk("wr_hwrite_r1",  32'(hwrite_reg_1), 32'd1);
      chk("wr_hwdata_1",   hwdata_1, 32'hDEAD_BEEF);
      chk("wr_haddr_1b",   haddr_1, 32'h8000_0100);
      chk("wr_hwrite_r0",  32'(hwrite_reg), 32'd0);

      // Stall: hready_in low for three cycles with the address moving
      nxt();
      hready_in = 1'b0; htrans = 2'b10; haddr = 32'h8000_0300;
      smp();
      chk("stall0_valid",  32'(valid), 32'd0);
      chk("stall0_haddr1", haddr_1, 32'h8000_0200);
      chk("stall0_haddr2", haddr_2, 32'h8000_0100);
      chk("stall0_hwd2",   hwdata_2, 32'hDEAD_BEEF);
      for (int i = 1; i < 3; i++) begin
         nxt();
         haddr = haddr + 32'h100;
         smp();
         chk("stall_valid",  32'(valid), 32'd0);
         chk("stall_haddr1", haddr_1, 32'h8000_0200);
         chk("stall_haddr2", haddr_2, 32'h8000_0100);
      end

      // BUSY then IDLE at mapped addresses
      nxt();
      hready_in = 1'b1; htrans = 2'b01; haddr = 32'h8000_0010;
      prdata = 32'hCAFE_F00D; hr_readyout = 1'b0;
      smp();
      chk("busy_haddr1",  haddr_1, 32'h8000_0200);
      chk("busy_valid",   32'(valid), 32'd0);
      chk("busy_hresp",   32'(hresp), 32'd0);
      chk("busy_ready",   32'(hreadyout), 32'd0);
      chk("busy_hrdata",  hrdata, 32'hCAFE_F00D);
      nxt();
      htrans = 2'b00; haddr = 32'h8000_0020; hr_readyout = 1'b1;
      smp();
      chk("idle_valid",  32'(valid), 32'd0);
      chk("idle_hresp",  32'(hresp), 32'd0);
      chk("idle_haddr1", haddr_1, 32'h8000_0010);
      chk("idle_haddr2", haddr_2, 32'h8000_0200);

      // Misaligned word read
      nxt();
      htrans = 2'b10; haddr = 32'h8000_0002; hsize = 3'b010; hwrite = 1'b0;
      smp();
      chk("mis_haddr1", haddr_1, 32'h8000_0020);
      chk("mis_haddr2", haddr_2, 32'h8000_0010);
      chk("mis_valid",  32'(valid), 32'd0);
      chk("mis_hresp",  32'(hresp), 32'd0);
      chk("mis_ready",  32'(hreadyout), 32'd1);
      nxt();
      haddr = 32'h8000_0010;
      smp();
      chk("err1_ready", 32'(hreadyout), exp_err_ready);
      chk("err1_hresp", 32'(hresp), exp_err_resp);
      chk("err1_valid", 32'(valid), exp_err_valid);
      nxt();
      htrans = 2'b00;
      smp();
      chk("err2_ready", 32'(hreadyout), 32'd1);
      chk("err2_hresp", 32'(hresp), exp_err_resp);
      chk("err2_valid", 32'(valid), 32'd0);
      nxt();
      smp();
      chk("post_hresp", 32'(hresp), 32'd0);
      chk("post_ready", 32'(hreadyout), 32'd1);

      // Reset taken while in the first error cycle
      nxt();
      htrans = 2'b10; haddr = 32'h8000_0001;
      nxt();
      hreset = 1'b1; htrans = 2'b00;
      nxt();
      hreset = 1'b0;
      smp();
      chk("rst_err_hresp", 32'(hresp), 32'd0);
      chk("rst_err_ready", 32'(hreadyout), 32'd1);
      chk("rst_err_haddr", haddr_1, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ahb_slave_if.md
Name: ahb_slave_if

Overview:
- AHB-side front end of the AHB-to-APB bridge, directly upstream of the APB controller FSM.
- Qualifies AHB transfers and decodes the address into a one-hot peripheral select.
- Holds two-stage address, data and direction pipelines so the controller can issue APB setup/enable phases one or two cycles after the AHB address phase.
- Returns read data and the transfer response to the AHB master.

Parameters:
- BASE_ADDR, 32'h8000_0000, base of the bridge address window.
- SLV_SIZE, 32'h0400_0000, size of each peripheral region; three regions are contiguous from BASE_ADDR.

Ports:
- hclk  input  1  bridge clock.
- hreset  input  1  synchronous reset, active-high.
- hsel  input  1  bridge selected by the AHB decoder.
- hwrite  input  1  AHB direction, 1 = write.
- hready_in  input  1  bus-wide HREADY; the address phase is sampled only when this is 1.
- htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hsize  input  3  transfer size.
- haddr  input  32  AHB address.
- hwdata  input  32  AHB write data.
- prdata  input  32  APB read data.
- hr_readyout  input  1  ready from the APB controller.
- valid  output  1  qualified transfer present this cycle.
- temp_sel  output  3  one-hot peripheral select.
- haddr_1  output  32  address pipeline, stage 1.
- haddr_2  output  32  address pipeline, stage 2.
- hwdata_1  output  32  write-data pipeline, stage 1.
- hwdata_2  output  32  write-data pipeline, stage 2.
- hwrite_reg  output  1  direction pipeline, stage 1.
- hwrite_reg_1  output  1  direction pipeline, stage 2.
- hrdata  output  32  AHB read data.
- hreadyout  output  1  AHB ready.
- hresp  output  2  AHB response, 00 OKAY, 01 ERROR.

Behaviour:
- Reset (hreset=1 at a rising hclk edge):
  - all pipeline registers <= 0; error FSM <= OK.
  - hreadyout = hr_readyout (passthrough); hresp = 00.
  - valid is forced 0 while hreset is 1.
- Active transfer: act = hsel & hready_in & htrans[1] (NONSEQ or SEQ). IDLE and BUSY never assert valid and always get OKAY.
- Address decode, combinational:
  - off = haddr - BASE_ADDR.
  - off < SLV_SIZE -> temp_sel=001; off < 2*SLV_SIZE -> 010; off < 3*SLV_SIZE -> 100.
  - Otherwise "unmapped": temp_sel=000.
  - Address exactly BASE_ADDR+3*SLV_SIZE is unmapped.
- Legal transfer: mapped, hsize <= 3'b010, and naturally aligned (halfword: haddr[0]=0; word: haddr[1:0]=0).
- valid = act & legal & ~hreset, combinational, same cycle as the address phase. temp_sel is driven whenever the address is mapped, regardless of act.
- Pipelines:
  - Advance on every rising edge where hready_in=1; hold when hready_in=0.
  - haddr_1<=haddr, haddr_2<=haddr_1.
  - hwdata_1<=hwdata, hwdata_2<=hwdata_1.
  - hwrite_reg<=hwrite, hwrite_reg_1<=hwrite_reg.
  - Latency 1 cycle to stage 1, 2 cycles to stage 2.
- hrdata = prdata, combinational, zero latency.
- Outside the error FSM: hreadyout = hr_readyout, hresp = 00.

Optional Feature:
- Macro: AHB_SLV_ERR_RESP_EN.
- Defined: three-state error FSM OK -> ERR1 -> ERR2 -> OK.
  - OK: if act & ~legal -> ERR1; otherwise stay in OK.
  - ERR1: hreadyout=0, hresp=01, valid=0; next state ERR2 unconditionally.
  - ERR2: hreadyout=1, hresp=01. A transfer presented in ERR2 is evaluated normally: a legal one asserts valid, an illegal one goes to ERR1, otherwise OK.
  - Reset in any state -> OK, hresp=00 on the following cycle.
  - Illegal transfers never reach the controller.
- Undefined: no FSM; an illegal transfer gives valid=0, hresp=00, hreadyout=hr_readyout (silently dropped, read data undefined).

Test Plan:
- Reset: hreset=1 for 2 cycles, then 0 -> haddr_1/haddr_2/hwdata_1/hwdata_2=0, hwrite_reg=0, hresp=00, valid=0 during reset.
- Decode: NONSEQ word reads at 0x8000_0010, 0x8400_0000, 0x8BFF_FFFC -> temp_sel 001, 010, 100, valid=1 in the same cycle. 0x8C00_0000 -> temp_sel=000, valid=0.
- Write pipeline:
  - NONSEQ write to 0x8000_0004 with hwdata=0xDEAD_BEEF in the following cycle, hready_in=1.
  - haddr_1=0x8000_0004 and hwrite_reg=1 after 1 edge; haddr_2=0x8000_0004 and hwrite_reg_1=1 after 2 edges.
  - hwdata_1=0xDEAD_BEEF one edge after data is driven.
- Stall: hold hready_in=0 for 3 cycles with haddr changing -> haddr_1/haddr_2 frozen; valid=0 throughout.
- BUSY/IDLE: htrans=01 then 00 at a mapped address -> valid=0, hresp=00, pipeline still advances.
- Error (macro defined):
  - NONSEQ word read at 0x8000_0002 -> ERR1 cycle hreadyout=0/hresp=01, ERR2 cycle hreadyout=1/hresp=01, valid=0 in both; next IDLE -> hresp=00.
  - Macro undefined: same stimulus -> hresp=00, valid=0.
